// File: rtl/cosim_commit_arbiter_if.sv
// cosim_commit_arbiter_if: per-hart event inputs and the shared hart-tagged cosim beat.
// Stat ports exist only when COSIM_ARB_STATS_EN is defined.
interface cosim_commit_arbiter_if #(
  parameter int NUM_HARTS = 4,
  parameter int XLEN = 64,
  parameter int INST_BITS = 32,
  parameter int HARTID_W = 2
);
  logic [NUM_HARTS-1:0] in_valid, in_ready, in_is_trap, in_check;
  logic [XLEN*NUM_HARTS-1:0] in_pc, in_wdata, in_mstatus;
  logic [INST_BITS*NUM_HARTS-1:0] in_inst;
  logic out_valid, out_check, out_int_xcpt, idle;
  logic [HARTID_W-1:0] out_hartid;
  logic [XLEN-1:0] out_pc, out_wdata, out_mstatus, out_cause;
  logic [INST_BITS-1:0] out_inst;
`ifdef COSIM_ARB_STATS_EN
  logic [32*NUM_HARTS-1:0] stat_commits, stat_stall_cycles;
  modport master (
    output in_valid, in_is_trap, in_pc, in_inst, in_wdata, in_mstatus, in_check,
    input in_ready, out_valid, out_hartid, out_pc, out_wdata, out_mstatus, out_inst,
    input out_check, out_int_xcpt, out_cause, idle, stat_commits, stat_stall_cycles
  );
  modport slave (
    input in_valid, in_is_trap, in_pc, in_inst, in_wdata, in_mstatus, in_check,
    output in_ready, out_valid, out_hartid, out_pc, out_wdata, out_mstatus, out_inst,
    output out_check, out_int_xcpt, out_cause, idle, stat_commits, stat_stall_cycles
  );
`else
  modport master (
    output in_valid, in_is_trap, in_pc, in_inst, in_wdata, in_mstatus, in_check,
    input in_ready, out_valid, out_hartid, out_pc, out_wdata, out_mstatus, out_inst,
    input out_check, out_int_xcpt, out_cause, idle
  );
  modport slave (
    input in_valid, in_is_trap, in_pc, in_inst, in_wdata, in_mstatus, in_check,
    output in_ready, out_valid, out_hartid, out_pc, out_wdata, out_mstatus, out_inst,
    output out_check, out_int_xcpt, out_cause, idle
  );
`endif
endinterface

// File: rtl/cosim_commit_arbiter.sv
// cosim_commit_arbiter: round-robin merge of per-hart commit/trap FIFOs onto one registered cosim beat.
// Define COSIM_ARB_STATS_EN to add saturating per-hart commit and stall counters.
module cosim_commit_arbiter #(
  parameter int NUM_HARTS = 4,
  parameter int XLEN = 64,
  parameter int INST_BITS = 32,
  parameter int HARTID_W = 2,
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic reset,
  cosim_commit_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int GW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1;
  logic [XLEN-1:0] pc_m [NUM_HARTS][DEPTH];
  logic [XLEN-1:0] wdata_m [NUM_HARTS][DEPTH];
  logic [XLEN-1:0] mstatus_m [NUM_HARTS][DEPTH];
  logic [INST_BITS-1:0] inst_m [NUM_HARTS][DEPTH];
  logic trap_m [NUM_HARTS][DEPTH];
  logic check_m [NUM_HARTS][DEPTH];
  logic [PW-1:0] wptr [NUM_HARTS];
  logic [PW-1:0] rptr [NUM_HARTS];
  logic [PW:0] count [NUM_HARTS];
  logic [NUM_HARTS-1:0] fresh, eligible, ready, push, pop, busy;
  logic [GW-1:0] last_grant, grant, cand;
  logic found, take_commit, take_trap, h_trap, h_check;
  logic [XLEN-1:0] h_pc, h_wdata, h_mstatus;
  logic [INST_BITS-1:0] h_inst;
  assign bus.in_ready = ready;
  assign push = bus.in_valid & ready;
  assign bus.idle = !(|busy) && !bus.out_valid && !bus.out_int_xcpt;
  // an entry pushed at the last edge must wait one full cycle before it can be granted
  always_comb begin
    busy = '0;
    eligible = '0;
    ready = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      busy[h] = count[h] != '0;
      eligible[h] = count[h] > (PW+1)'(fresh[h]);
      ready[h] = count[h] != (PW+1)'(DEPTH);
    end
  end
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    cand = '0;
    for (int i = NUM_HARTS; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % NUM_HARTS);
      if (eligible[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    pop = found ? NUM_HARTS'(1) << grant : '0;
    h_trap = trap_m[grant][rptr[grant]];
    h_check = check_m[grant][rptr[grant]];
    h_pc = pc_m[grant][rptr[grant]];
    h_wdata = wdata_m[grant][rptr[grant]];
    h_mstatus = mstatus_m[grant][rptr[grant]];
    h_inst = inst_m[grant][rptr[grant]];
    take_commit = found && !h_trap;
    take_trap = found && h_trap;
  end
  always_ff @(posedge clock) begin
    for (int h = 0; h < NUM_HARTS; h++)
      if (push[h]) begin
        pc_m[h][wptr[h]] <= bus.in_pc[h*XLEN +: XLEN];
        wdata_m[h][wptr[h]] <= bus.in_wdata[h*XLEN +: XLEN];
        mstatus_m[h][wptr[h]] <= bus.in_mstatus[h*XLEN +: XLEN];
        inst_m[h][wptr[h]] <= bus.in_inst[h*INST_BITS +: INST_BITS];
        trap_m[h][wptr[h]] <= bus.in_is_trap[h];
        check_m[h][wptr[h]] <= bus.in_check[h];
      end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        wptr[h] <= '0;
        rptr[h] <= '0;
        count[h] <= '0;
      end
      fresh <= '0;
      last_grant <= GW'(NUM_HARTS - 1);
      bus.out_valid <= 1'b0;
      bus.out_int_xcpt <= 1'b0;
      bus.out_hartid <= '0;
      bus.out_pc <= '0;
      bus.out_wdata <= '0;
      bus.out_mstatus <= '0;
      bus.out_inst <= '0;
      bus.out_check <= 1'b0;
      bus.out_cause <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        wptr[h] <= wptr[h] + PW'(push[h]);
        rptr[h] <= rptr[h] + PW'(pop[h]);
        count[h] <= count[h] + (PW+1)'(push[h]) - (PW+1)'(pop[h]);
      end
      fresh <= push;
      if (found) last_grant <= grant;
      bus.out_valid <= take_commit;
      bus.out_int_xcpt <= take_trap;
      bus.out_hartid <= found ? HARTID_W'(grant) : '0;
      bus.out_pc <= take_commit ? h_pc : '0;
      bus.out_wdata <= take_commit ? h_wdata : '0;
      bus.out_mstatus <= take_commit ? h_mstatus : '0;
      bus.out_inst <= take_commit ? h_inst : '0;
      bus.out_check <= take_commit && h_check;
      bus.out_cause <= take_trap ? h_wdata : '0;
    end
  end
`ifdef COSIM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    for (int h = 0; h < NUM_HARTS; h++)
      if (reset) begin
        bus.stat_commits[h*32 +: 32] <= '0;
        bus.stat_stall_cycles[h*32 +: 32] <= '0;
      end else begin
        if (pop[h] && !h_trap && bus.stat_commits[h*32 +: 32] != '1)
          bus.stat_commits[h*32 +: 32] <= bus.stat_commits[h*32 +: 32] + 32'd1;
        if (bus.in_valid[h] && !ready[h] && bus.stat_stall_cycles[h*32 +: 32] != '1)
          bus.stat_stall_cycles[h*32 +: 32] <= bus.stat_stall_cycles[h*32 +: 32] + 32'd1;
      end
  end
`endif
endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// tb_cosim_commit_arbiter: directed and random stimulus checked each cycle against a queue-based model.
module tb_cosim_commit_arbiter;
  localparam int NH = 4;
  localparam int XL = 64;
  localparam int IB = 32;
  localparam int HW = 2;
  localparam int D = 4;
  typedef struct packed {
    logic trap;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wd;
    logic [63:0] ms;
    logic ck;
    int st;
  } ev_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  ev_t q [NH][$];
  ev_t ev, tmp;
  int last_g, cg, ecount, total, pct;
  bit got, model_on;
  logic e_v, e_x, e_ck;
  logic [1:0] e_h;
  logic [63:0] e_pc, e_wd, e_ms, e_cause;
  logic [31:0] e_inst;
  logic [NH-1:0] rdy;
  longint s_com [NH];
  longint s_stall [NH];
  int n_chk = 0;
  int n_fail = 0;

  cosim_commit_arbiter_if #(.NUM_HARTS(NH), .XLEN(XL), .INST_BITS(IB), .HARTID_W(HW)) bus ();
  cosim_commit_arbiter #(.NUM_HARTS(NH), .XLEN(XL), .INST_BITS(IB), .HARTID_W(HW), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  initial forever #5 clock = ~clock;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    bus.in_valid = '0;
    bus.in_is_trap = '0;
    bus.in_check = '0;
    bus.in_pc = '0;
    bus.in_wdata = '0;
    bus.in_mstatus = '0;
    bus.in_inst = '0;
  endtask

  task automatic put(int h, logic tr, logic [63:0] pc, logic [31:0] ins, logic [63:0] wd, logic ck);
    bus.in_valid[h] = 1'b1;
    bus.in_is_trap[h] = tr;
    bus.in_pc[h*XL +: XL] = pc;
    bus.in_inst[h*IB +: IB] = ins;
    bus.in_wdata[h*XL +: XL] = wd;
    bus.in_mstatus[h*XL +: XL] = ~pc;
    bus.in_check[h] = ck;
  endtask

  task automatic rst_seq();
    clr();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // reference model: FIFO queues, entries become grantable one cycle after acceptance
  initial forever begin
    @(negedge clock);
    total = 0;
    for (int h = 0; h < NH; h++) begin
      rdy[h] = q[h].size() < D;
      total += q[h].size();
    end
    if (model_on) begin
      chk("out_valid", 64'(bus.out_valid), 64'(e_v));
      chk("out_int_xcpt", 64'(bus.out_int_xcpt), 64'(e_x));
      chk("out_hartid", 64'(bus.out_hartid), 64'(e_h));
      chk("out_pc", bus.out_pc, e_pc);
      chk("out_wdata", bus.out_wdata, e_wd);
      chk("out_mstatus", bus.out_mstatus, e_ms);
      chk("out_inst", 64'(bus.out_inst), 64'(e_inst));
      chk("out_check", 64'(bus.out_check), 64'(e_ck));
      chk("out_cause", bus.out_cause, e_cause);
      chk("in_ready", 64'(bus.in_ready), 64'(rdy));
      chk("idle", 64'(bus.idle), 64'(total == 0 && !e_v && !e_x));
`ifdef COSIM_ARB_STATS_EN
      for (int h = 0; h < NH; h++) begin
        chk("stat_commits", 64'(bus.stat_commits[h*32 +: 32]), 64'(s_com[h]));
        chk("stat_stall", 64'(bus.stat_stall_cycles[h*32 +: 32]), 64'(s_stall[h]));
      end
`endif
    end
    ecount++;
    e_v = 0; e_x = 0; e_h = 0; e_pc = 0; e_wd = 0; e_ms = 0; e_inst = 0; e_ck = 0; e_cause = 0;
    if (reset) begin
      for (int h = 0; h < NH; h++) begin
        q[h].delete();
        s_com[h] = 0;
        s_stall[h] = 0;
      end
      last_g = NH - 1;
      model_on = 1;
    end else if (model_on) begin
      got = 0;
      for (int i = 1; i <= NH; i++)
        if (!got) begin
          cg = (last_g + i) % NH;
          if (q[cg].size() > 0 && q[cg][0].st <= ecount - 2) begin
            got = 1;
            last_g = cg;
            ev = q[cg].pop_front();
          end
        end
      if (got) begin
        e_h = 2'(cg);
        if (ev.trap) begin
          e_x = 1;
          e_cause = ev.wd;
        end else begin
          e_v = 1; e_pc = ev.pc; e_wd = ev.wd; e_ms = ev.ms; e_inst = ev.inst; e_ck = ev.ck;
          s_com[cg]++;
        end
      end
      for (int h = 0; h < NH; h++) begin
        if (bus.in_valid[h] && !rdy[h]) s_stall[h]++;
        if (bus.in_valid[h] && rdy[h]) begin
          tmp.trap = bus.in_is_trap[h];
          tmp.pc = bus.in_pc[h*XL +: XL];
          tmp.inst = bus.in_inst[h*IB +: IB];
          tmp.wd = bus.in_wdata[h*XL +: XL];
          tmp.ms = bus.in_mstatus[h*XL +: XL];
          tmp.ck = bus.in_check[h];
          tmp.st = ecount;
          q[h].push_back(tmp);
        end
      end
    end
  end

  initial begin
    clr();
    rst_seq();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_int_xcpt", 64'(bus.out_int_xcpt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'hf);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    // single commit: accepted at edge t, visible only after edge t+2
    put(0, 1'b0, 64'h80000000, 32'h00000013, 64'd0, 1'b1);
    cyc();
    clr();
    chk("single_t0", 64'(bus.out_valid), 64'd0);
    cyc();
    chk("single_t1", 64'(bus.out_valid), 64'd0);
    cyc();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_hartid", 64'(bus.out_hartid), 64'd0);
    chk("single_pc", bus.out_pc, 64'h80000000);
    chk("single_inst", 64'(bus.out_inst), 64'h13);
    chk("single_check", 64'(bus.out_check), 64'd1);
    cyc();
    chk("single_gone", 64'(bus.out_valid), 64'd0);
    chk("single_idle", 64'(bus.idle), 64'd1);
    // round-robin over four loaded harts
    rst_seq();
    for (int r = 0; r < 3; r++) begin
      for (int h = 0; h < NH; h++) put(h, 1'b0, 64'h1000 + 64'(h*16 + r), 32'(h), 64'(r), 1'b0);
      cyc();
    end
    clr();
    for (int k = 0; k < 12; k++) begin
      chk("rr_valid", 64'(bus.out_valid), 64'd1);
      chk("rr_hartid", 64'(bus.out_hartid), 64'(k % 4));
      chk("rr_pc", bus.out_pc, 64'h1000 + 64'((k % 4) * 16 + k / 4));
      cyc();
    end
    chk("rr_done", 64'(bus.out_valid), 64'd0);
    // trap ordering on hart 2
    rst_seq();
    put(2, 1'b0, 64'h100, 32'h13, 64'h5, 1'b1);
    cyc();
    put(2, 1'b1, 64'h0, 32'h0, 64'h8000000000000007, 1'b0);
    cyc();
    put(2, 1'b0, 64'h104, 32'h13, 64'h6, 1'b1);
    cyc();
    clr();
    chk("trap_c1_valid", 64'(bus.out_valid), 64'd1);
    chk("trap_c1_pc", bus.out_pc, 64'h100);
    chk("trap_c1_hart", 64'(bus.out_hartid), 64'd2);
    cyc();
    chk("trap_xcpt", 64'(bus.out_int_xcpt), 64'd1);
    chk("trap_valid0", 64'(bus.out_valid), 64'd0);
    chk("trap_cause", bus.out_cause, 64'h8000000000000007);
    chk("trap_hart", 64'(bus.out_hartid), 64'd2);
    cyc();
    chk("trap_c2_valid", 64'(bus.out_valid), 64'd1);
    chk("trap_c2_pc", bus.out_pc, 64'h104);
    chk("trap_c2_hart", 64'(bus.out_hartid), 64'd2);
    // all harts saturating: hart 1 fills after edge 5, then stalls on edges 6,7,8,10,11
    rst_seq();
    for (int e = 1; e <= 11; e++) begin
      for (int h = 0; h < NH; h++) put(h, 1'b0, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, 1'b1);
      cyc();
      if (e == 4) chk("full_e4_ready1", 64'(bus.in_ready[1]), 64'd1);
      if (e == 5) chk("full_e5_ready1", 64'(bus.in_ready[1]), 64'd0);
      if (e == 8) chk("full_e8_ready1", 64'(bus.in_ready[1]), 64'd1);
      if (e == 9) chk("full_e9_ready1", 64'(bus.in_ready[1]), 64'd0);
    end
    clr();
`ifdef COSIM_ARB_STATS_EN
    chk("stat_stall_h1", 64'(bus.stat_stall_cycles[32 +: 32]), 64'd5);
`endif
    repeat (30) cyc();
    chk("full_drained_idle", 64'(bus.idle), 64'd1);
    // reset mid-stream drops queued events
    rst_seq();
    for (int r = 0; r < 3; r++) begin
      for (int h = 0; h < NH; h++) put(h, 1'b0, 64'h3000 + 64'(r), 32'h13, 64'd0, 1'b0);
      cyc();
    end
    clr();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_xcpt", 64'(bus.out_int_xcpt), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'hf);
    chk("midrst_idle", 64'(bus.idle), 64'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("midrst_quiet", 64'(bus.out_valid | bus.out_int_xcpt), 64'd0);
    end
`ifdef COSIM_ARB_STATS_EN
    rst_seq();
    for (int k = 0; k < 10; k++) begin
      put(0, 1'b0, 64'h2000 + 64'(k), 32'h13, 64'd0, 1'b0);
      cyc();
    end
    clr();
    repeat (4) cyc();
    chk("stat_commits_h0", 64'(bus.stat_commits[0 +: 32]), 64'd10);
`endif
    // random traffic with occasional reset, density varied by phase
    for (int c = 0; c < 3000; c++) begin
      clr();
      reset = $urandom_range(0, 299) == 0;
      pct = (c / 500) % 3 == 0 ? 25 : (c / 500) % 3 == 1 ? 50 : 90;
      for (int h = 0; h < NH; h++)
        if ($urandom_range(0, 99) < pct)
          put(h, $urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, 1'($urandom));
      cyc();
    end
    clr();
    reset = 1'b0;
    repeat (30) cyc();
    chk("final_idle", 64'(bus.idle), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cosim_commit_arbiter.md
Name: cosim_commit_arbiter

Overview:
- Shares one single-commit-wide Dromajo co-simulation port between NUM_HARTS cores.
- Each hart pushes an ordered event stream of commits and traps into a per-hart FIFO.
- A round-robin scheduler pops one event per cycle and drives a registered, hart-tagged commit-or-trap beat toward the cosim black box (COMMIT_WIDTH=1, HARTID_LEN=HARTID_W).
- Per-hart ordering of commits versus traps is preserved.

Parameters:
- NUM_HARTS, 4, number of requesting harts (>=1).
- XLEN, 64, data/PC width.
- INST_BITS, 32, instruction width.
- HARTID_W, 2, width of out_hartid; must satisfy 2^HARTID_W >= NUM_HARTS.
- DEPTH, 4, entries per hart FIFO; power of 2, >=2.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_HARTS  per-hart event valid
- in_ready  out  NUM_HARTS  per-hart accept (= FIFO not full)
- in_is_trap  in  NUM_HARTS  1: event is trap; 0: event is commit
- in_pc  in  XLEN*NUM_HARTS  commit PC, hart h at [h*XLEN +: XLEN]
- in_inst  in  INST_BITS*NUM_HARTS  commit instruction
- in_wdata  in  XLEN*NUM_HARTS  commit writeback data; carries the trap cause when in_is_trap=1
- in_mstatus  in  XLEN*NUM_HARTS  commit mstatus
- in_check  in  NUM_HARTS  commit check flag
- out_valid  out  1  commit beat valid
- out_hartid  out  HARTID_W  source hart of the beat
- out_pc, out_wdata, out_mstatus  out  XLEN  commit fields
- out_inst  out  INST_BITS  commit instruction
- out_check  out  1  commit check flag
- out_int_xcpt  out  1  trap beat valid
- out_cause  out  XLEN  trap cause
- idle  out  1  all FIFOs empty and no beat on the outputs

Behaviour:
- Reset:
  - all FIFO pointers and counts are 0.
  - out_valid=0, out_int_xcpt=0; all other outputs are 0.
  - last_grant=NUM_HARTS-1, so hart 0 has first priority.
  - idle=1.
  - in_ready=all ones from the first cycle after reset.
  - Reset asserted mid-stream discards all queued events with no output beat.
- Enqueue: hart h pushes when in_valid[h] && in_ready[h]. in_ready[h]=!full[h], combinational from count only; no bypass when full.
- Schedule, each cycle:
  - Search the nonempty FIFOs starting at (last_grant+1) mod NUM_HARTS, wrapping.
  - Pop the first nonempty FIFO found and set last_grant to it.
  - If no FIFO is nonempty, pop nothing and leave last_grant unchanged.
- Output register, loaded every cycle:
  - Popped commit: out_valid=1, out_int_xcpt=0, commit fields from the entry, out_cause=0.
  - Popped trap: out_int_xcpt=1, out_valid=0, out_cause=entry wdata; commit fields are don't-care but driven 0.
  - Nothing popped: out_valid=0, out_int_xcpt=0.
  - The outputs are never both 1. No backpressure exists at the output.
- Latency: an event accepted at edge t is eligible during cycle t+1. With no contention, its beat is visible from edge t+2 for exactly one cycle.
- Simultaneous push and pop on the same FIFO are legal at any count below DEPTH; the count is unchanged.
- Throughput: 1 event/cycle aggregate. With K harts continuously nonempty, each is granted exactly once every K cycles.
- Pointers are log2(DEPTH) bits wide with natural wrap; count is log2(DEPTH)+1 bits.
- out_hartid is the grant index zero-extended to HARTID_W.

Optional Feature:
- Macro: COSIM_ARB_STATS_EN.
- When defined:
  - Adds output stat_commits (32*NUM_HARTS) and stat_stall_cycles (32*NUM_HARTS).
  - stat_commits[h] increments on each commit beat output for hart h.
  - stat_stall_cycles[h] increments each cycle in_valid[h] && !in_ready[h].
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined: the ports and counters are absent, and the other behaviour is identical.

Test Plan:
- Single commit: after reset, hart 0 pushes pc=0x80000000, inst=0x00000013, check=1 at edge 5 → out_valid=1, out_hartid=0, out_pc=0x80000000 at edge 7 only; idle=1 from edge 8.
- Round-robin: harts 0..3 each preload 3 commits, then arbitration starts → out_hartid sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no gaps.
- Trap ordering: hart 2 pushes commit pc=0x100, trap cause=0x8000000000000007, commit pc=0x104 → out_valid(0x100), then out_int_xcpt with out_cause=0x8000000000000007, then out_valid(0x104), all with hartid=2.
- Full/backpressure: hold hart 1's FIFO undrained (hart 0 flooding is insufficient due to RR, so pause by reset release timing). Expected: fill hart 1 with DEPTH=4 entries while other harts are saturating → in_ready[1]=0 when count=4; a push attempt is not accepted; the entry order out is preserved.
- Reset mid-operation: with 3 queued events on hart 3, assert reset for 1 cycle → no beat for those events; in_ready=1111 and idle=1 after reset.
- With COSIM_ARB_STATS_EN: 10 commits from hart 0 and 5 stall cycles on hart 1 → stat_commits[0]=10, stat_stall_cycles[1]=5.
